ram_master: RTL and testbench

RAM_MASTER -- requirements
Module: ram_master

---
 rtl/ram_master.sv | 107 ++++++++++
 tb/tb_ram_master.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_master.sv
// Command-driven controller for a synchronous single-port RAM.
// Handles single-word reads/writes and a whole-array zero-fill sweep.
module ram_master #(
    parameter int SIZE  = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_write,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [SIZE-1:0] cmd_data,
    input  logic            clr,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [SIZE-1:0] rsp_data,
    output logic [AW-1:0]   rsp_addr,
    output logic            busy,
    output logic [AW-1:0]   ram_address,
    output logic [SIZE-1:0] ram_write_data,
    output logic            ram_write_en,
    input  logic [SIZE-1:0] ram_read_data
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        CLEAR
    } state_e;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_e        state;
    logic [AW-1:0] clr_cnt;

    assign cmd_ready = (state == IDLE) && !clr && rst;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            clr_cnt        <= '0;
            ram_address    <= '0;
            ram_write_data <= '0;
            ram_write_en   <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            rsp_addr       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    ram_write_en <= 1'b0;
                    if (clr) begin
                        state          <= CLEAR;
                        clr_cnt        <= '0;
                        ram_address    <= '0;
                        ram_write_data <= '0;
                        ram_write_en   <= 1'b1;
                    end else if (cmd_valid) begin
                        state        <= ISSUE;
                        ram_address  <= cmd_addr;
                        ram_write_en <= cmd_write;
                        if (cmd_write) begin
                            ram_write_data <= cmd_data;
                        end
                    end
                end
                ISSUE: begin
                    // a write finishes here; a read waits for RAM latency
                    ram_write_en <= 1'b0;
                    state        <= ram_write_en ? IDLE : WAIT;
                end
                WAIT: begin
                    rsp_data  <= ram_read_data;
                    rsp_addr  <= ram_address;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                CLEAR: begin
                    if (clr_cnt == LAST) begin
                        ram_write_en <= 1'b0;
                        clr_cnt      <= '0;
                        state        <= IDLE;
                    end else begin
                        clr_cnt     <= clr_cnt + 1'b1;
                        ram_address <= clr_cnt + 1'b1;
                    end
                end
                default: begin
                    ram_write_en <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_master.sv
// Directed bench for ram_master with behavioural RAM models,
// one instance at DEPTH=16 and one at DEPTH=10.
module tb_ram_master;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       preload = 1'b0;

    logic       cmd_valid = 1'b0, cmd_write = 1'b0, clr = 1'b0, rsp_ready = 1'b0;
    logic [3:0] cmd_addr = '0;
    logic [7:0] cmd_data = '0;
    logic       cmd_ready, rsp_valid, busy, we;
    logic [7:0] rsp_data, wd, rd;
    logic [3:0] rsp_addr, addr;

    logic       clr2 = 1'b0;
    logic       cmd_ready2, rsp_valid2, busy2, we2;
    logic [7:0] rsp_data2, wd2, rd2;
    logic [3:0] rsp_addr2, addr2;

    logic [7:0] mem  [16];
    logic [7:0] mem2 [16];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_master #(.SIZE(8), .DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .clr(clr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_addr(rsp_addr),
        .busy(busy),
        .ram_address(addr), .ram_write_data(wd),
        .ram_write_en(we), .ram_read_data(rd)
    );

    ram_master #(.SIZE(8), .DEPTH(10)) dut2 (
        .clk(clk), .rst(rst),
        .cmd_valid(1'b0), .cmd_ready(cmd_ready2),
        .cmd_write(1'b0), .cmd_addr(4'd0), .cmd_data(8'd0),
        .clr(clr2),
        .rsp_valid(rsp_valid2), .rsp_ready(1'b0),
        .rsp_data(rsp_data2), .rsp_addr(rsp_addr2),
        .busy(busy2),
        .ram_address(addr2), .ram_write_data(wd2),
        .ram_write_en(we2), .ram_read_data(rd2)
    );

    // synchronous read-first RAMs
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) begin
                mem[i]  <= 8'h10 + 8'(i);
                mem2[i] <= 8'h10 + 8'(i);
            end
        end else begin
            if (we)  mem[addr]   <= wd;
            if (we2) mem2[addr2] <= wd2;
        end
        rd  <= mem[addr];
        rd2 <= mem2[addr2];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_data = d;
        tick();
        cmd_valid = 1'b0; cmd_write = 1'b0;
        tick();
    endtask

    task automatic wait_rsp(input string tag);
        int k = 0;
        while (!rsp_valid && k < 10) begin
            tick();
            k++;
        end
        if (!rsp_valid) chk({tag, "_timeout"}, 32'(rsp_valid), 32'd1);
    endtask

    initial begin
        int n;
        int maxa;
        int bad;

        preload = 1'b1;
        tick();
        preload = 1'b0;
        tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_wd", 32'(wd), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_addr", 32'(rsp_addr), 32'd0);

        rst = 1'b1;
        tick();
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_we", 32'(we), 32'd0);

        // write 0xA5 to addr 5
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd5; cmd_data = 8'hA5;
        tick();
        cmd_valid = 1'b0; cmd_write = 1'b0;
        chk("wr_we", 32'(we), 32'd1);
        chk("wr_addr", 32'(addr), 32'd5);
        chk("wr_wd", 32'(wd), 32'hA5);
        chk("wr_busy", 32'(busy), 32'd1);
        chk("wr_cmd_ready_busy", 32'(cmd_ready), 32'd0);
        tick();
        chk("wr_done_ready", 32'(cmd_ready), 32'd1);
        chk("wr_done_we", 32'(we), 32'd0);
        chk("wr_mem5", 32'(mem[5]), 32'hA5);
        chk("idle_addr_hold", 32'(addr), 32'd5);

        // write 0x3C to 9 then read it back with stalled rsp_ready
        do_write(4'd9, 8'h3C);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'd9; cmd_data = 8'hFF;
        tick();
        cmd_valid = 1'b0; cmd_addr = 4'd2;
        chk("rd_issue_we", 32'(we), 32'd0);
        chk("rd_issue_addr", 32'(addr), 32'd9);
        tick();
        chk("rd_wait_valid", 32'(rsp_valid), 32'd0);
        tick();
        for (int c = 0; c < 4; c++) begin
            chk("rd_hold_valid", 32'(rsp_valid), 32'd1);
            chk("rd_hold_data", 32'(rsp_data), 32'h3C);
            chk("rd_hold_addr", 32'(rsp_addr), 32'd9);
            if (c < 3) tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rd_drop_valid", 32'(rsp_valid), 32'd0);
        chk("rd_drop_busy", 32'(busy), 32'd0);

        // read addr 5 with rsp_ready already high; clr pulsed while busy
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'd5;
        tick();
        cmd_valid = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        chk("rd2_valid", 32'(rsp_valid), 32'd1);
        chk("rd2_data", 32'(rsp_data), 32'hA5);
        chk("rd2_addr", 32'(rsp_addr), 32'd5);
        tick();
        rsp_ready = 1'b0;
        chk("rd2_one_cycle", 32'(rsp_valid), 32'd0);
        chk("clr_busy_ignored", 32'(busy), 32'd0);
        tick();
        chk("clr_busy_no_we", 32'(we), 32'd0);
        chk("clr_busy_mem0", 32'(mem[0]), 32'h10);

        // sweep aborted by reset once address 5 has been written
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("abort_start_addr", 32'(addr), 32'd0);
        for (int c = 1; c <= 5; c++) tick();
        chk("abort_at5_addr", 32'(addr), 32'd5);
        chk("abort_at5_we", 32'(we), 32'd1);
        rst = 1'b0;
        tick();
        chk("abort_we", 32'(we), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_addr", 32'(addr), 32'd0);
        chk("abort_mem5", 32'(mem[5]), 32'h00);
        chk("abort_mem6", 32'(mem[6]), 32'h16);
        chk("abort_mem9", 32'(mem[9]), 32'h3C);
        chk("abort_mem15", 32'(mem[15]), 32'h1F);
        rst = 1'b1;
        tick();

        // clr beats a same-cycle command; full sweep of 16
        clr = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd3; cmd_data = 8'h77;
        #1;
        chk("clr_prio_ready", 32'(cmd_ready), 32'd0);
        tick();
        clr = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
        chk("clr_we0", 32'(we), 32'd1);
        chk("clr_addr0", 32'(addr), 32'd0);
        chk("clr_wd0", 32'(wd), 32'd0);
        bad = 0;
        for (int c = 1; c < 16; c++) begin
            tick();
            if (addr !== 4'(c) || we !== 1'b1 || wd !== 8'h00) bad++;
        end
        chk("clr_seq_errors", 32'(bad), 32'd0);
        tick();
        chk("clr_end_we", 32'(we), 32'd0);
        chk("clr_end_busy", 32'(busy), 32'd0);
        bad = 0;
        for (int i = 0; i < 16; i++) if (mem[i] !== 8'h00) bad++;
        chk("clr_mem_nonzero", 32'(bad), 32'd0);

        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'd9;
        tick();
        cmd_valid = 1'b0;
        wait_rsp("clr_rd9");
        chk("clr_rd9_data", 32'(rsp_data), 32'h00);
        chk("clr_rd9_addr", 32'(rsp_addr), 32'd9);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // DEPTH=10 sweep
        clr2 = 1'b1;
        tick();
        clr2 = 1'b0;
        n = 0;
        maxa = 0;
        for (int k = 0; k < 20 && busy2; k++) begin
            if (we2) begin
                n++;
                if (int'(addr2) > maxa) maxa = int'(addr2);
            end
            tick();
        end
        chk("d10_writes", 32'(n), 32'd10);
        chk("d10_max_addr", 32'(maxa), 32'd9);
        chk("d10_busy", 32'(busy2), 32'd0);
        chk("d10_we", 32'(we2), 32'd0);
        chk("d10_mem9", 32'(mem2[9]), 32'h00);
        chk("d10_mem10", 32'(mem2[10]), 32'h1A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
